// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit owning HI/LO
// Results are computed at accept time, held in temp registers, and committed after a fixed latency.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MD_Op,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic [1:0]  E_MD_Rd,
  output logic [31:0] E_MD_Out,
  output logic        E_MD_Start,
  output logic        E_MD_Busy,
  output logic        E_MD_Stall_Req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_hi, r_lo, r_tmp_hi, r_tmp_lo;
  logic          r_wb;
  logic          w_done;

  logic w_op_mult, w_op_multu, w_op_div, w_op_divu, w_op_mthi, w_op_mtlo;
  logic w_op_mul, w_op_dv;

  assign w_op_mult  = (E_MD_Op == 4'd1);
  assign w_op_multu = (E_MD_Op == 4'd2);
  assign w_op_div   = (E_MD_Op == 4'd3);
  assign w_op_divu  = (E_MD_Op == 4'd4);
  assign w_op_mthi  = (E_MD_Op == 4'd5);
  assign w_op_mtlo  = (E_MD_Op == 4'd6);
  assign w_op_mul   = w_op_mult | w_op_multu;
  assign w_op_dv    = w_op_div | w_op_divu;

  // One 64-bit multiplier: sign-extend only for mult; the low 64 bits are exact either way.
  logic [63:0] w_ma, w_mb, w_prod;
  assign w_ma   = {{32{E_RD1[31] & w_op_mult}}, E_RD1};
  assign w_mb   = {{32{E_RD2[31] & w_op_mult}}, E_RD2};
  assign w_prod = w_ma * w_mb;

  // Signed divide runs on magnitudes through the shared unsigned divider, then fixes signs.
  logic [31:0] w_abs_a, w_abs_b, w_dvd, w_dvs_raw, w_dvs, w_q, w_r, w_quo, w_rem;
  assign w_abs_a   = E_RD1[31] ? (~E_RD1 + 32'd1) : E_RD1;
  assign w_abs_b   = E_RD2[31] ? (~E_RD2 + 32'd1) : E_RD2;
  assign w_dvd     = w_op_div ? w_abs_a : E_RD1;
  assign w_dvs_raw = w_op_div ? w_abs_b : E_RD2;
  assign w_dvs     = (w_dvs_raw == 32'd0) ? 32'd1 : w_dvs_raw;
  assign w_q       = w_dvd / w_dvs;
  assign w_r       = w_dvd % w_dvs;
  assign w_quo     = (w_op_div && (E_RD1[31] ^ E_RD2[31])) ? (~w_q + 32'd1) : w_q;
  assign w_rem     = (w_op_div && E_RD1[31]) ? (~w_r + 32'd1) : w_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    E_MD_Start  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_op_mul || w_op_dv) begin
          E_MD_Start  = 1'b1;
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_op_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(1)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
      r_wb     <= 1'b0;
    end else begin
      if (E_MD_Start) begin
        r_tmp_hi <= w_op_mul ? w_prod[63:32] : w_rem;
        r_tmp_lo <= w_op_mul ? w_prod[31:0]  : w_quo;
        // Divide by zero still occupies the unit but leaves HI/LO untouched.
        r_wb     <= !(w_op_dv && (E_RD2 == 32'd0));
      end
      if (w_done) begin
        if (r_wb) begin
          r_hi <= r_tmp_hi;
          r_lo <= r_tmp_lo;
        end
      end else if (r_state == S_IDLE) begin
        if (w_op_mthi) r_hi <= E_RD1;
        if (w_op_mtlo) r_lo <= E_RD1;
      end
    end
  end

  always_comb begin
    E_MD_Out = 32'd0;
    case (E_MD_Rd)
      2'd1:    E_MD_Out = r_hi;
      2'd2:    E_MD_Out = r_lo;
      default: E_MD_Out = 32'd0;
    endcase
  end

  assign E_MD_Busy      = (r_state == S_BUSY);
  assign E_MD_Stall_Req = E_MD_Start | E_MD_Busy;
  assign HI             = r_hi;
  assign LO             = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rd1, rd2;
  logic [1:0]  rd;
  logic [31:0] out, hi, lo;
  logic        start, busy, stall;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .E_MD_Op(op), .E_RD1(rd1), .E_RD2(rd2), .E_MD_Rd(rd),
    .E_MD_Out(out), .E_MD_Start(start), .E_MD_Busy(busy), .E_MD_Stall_Req(stall),
    .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    bit          keep;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi, m_lo;
  vec_t        tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic busy_phase(input bit junk, output int bcnt, output int scnt,
                            output int xstart, output int rdbad);
    bit fin = 1'b0;
    bcnt = 0; scnt = 0; xstart = 0; rdbad = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      if (!busy) begin
        op  = 4'd0;
        fin = 1'b1;
        #1;
      end else begin
        bcnt++;
        rd1 = $urandom;
        rd2 = $urandom;
        if (junk) begin
          op = (k % 2 == 0) ? 4'd3 : 4'd5;
          rd = 2'd1;
        end else begin
          op = 4'd0;
        end
        #1;
        if (stall) scnt++;
        if (start) xstart++;
        if (junk && out !== m_hi) rdbad++;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v, input bit junk, input bit same);
    logic        st, sr;
    logic [63:0] e;
    int          bcnt, scnt, xstart, rdbad;
    if (!same) @(negedge clk);
    op = v.op; rd1 = v.a; rd2 = v.b;
    #1;
    st = start; sr = stall;
    sb.push_back(v.keep ? {m_hi, m_lo} : {v.hi, v.lo});
    busy_phase(junk, bcnt, scnt, xstart, rdbad);
    check({name, "_start"}, 32'(st), 32'd1);
    check({name, "_busycnt"}, 32'(bcnt), 32'(v.n));
    check({name, "_stallcnt"}, 32'(scnt) + 32'(sr), 32'(v.n + 1));
    check({name, "_restart"}, 32'(xstart), 32'd0);
    if (junk) check({name, "_rdbusy"}, 32'(rdbad), 32'd0);
    e = sb.pop_front();
    check({name, "_hi"}, hi, e[63:32]);
    check({name, "_lo"}, lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    tbl[0]  = '{4'd1, 32'hFFFFFFFE, 32'h00000003, MULT_N, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_N, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    tbl[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, DIV_N,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3]  = '{4'd4, 32'h00000007, 32'h00000000, DIV_N,  1'b1, 32'h0,        32'h0};
    tbl[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, DIV_N,  1'b0, 32'h00000000, 32'h80000000};
    tbl[5]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, DIV_N,  1'b0, 32'h00000001, 32'hFFFFFFFD};
    tbl[6]  = '{4'd4, 32'hFFFFFFFF, 32'h00000010, DIV_N,  1'b0, 32'h0000000F, 32'h0FFFFFFF};
    tbl[7]  = '{4'd1, 32'h80000000, 32'h80000000, MULT_N, 1'b0, 32'h40000000, 32'h00000000};
    tbl[8]  = '{4'd2, 32'h80000000, 32'h00000002, MULT_N, 1'b0, 32'h00000001, 32'h00000000};
    tbl[9]  = '{4'd3, 32'h00000005, 32'h00000000, DIV_N,  1'b1, 32'h0,        32'h0};
    tbl[10] = '{4'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, DIV_N,  1'b0, 32'hFFFFFFFE, 32'h00000002};

    reset = 1'b1; op = 4'd0; rd1 = 32'd0; rd2 = 32'd0; rd = 2'd1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_out", out, 32'd0);

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), tbl[i], 1'b0, 1'b0);

    @(negedge clk);
    op = 4'd5; rd1 = 32'h12345678; rd = 2'd1;
    #1;
    check("mthi_stall", 32'(stall), 32'd0);
    @(negedge clk);
    op = 4'd6; rd1 = 32'h9ABCDEF0; rd = 2'd1;
    #1;
    check("mthi_out", out, 32'h12345678);
    check("mtlo_stall", 32'(stall), 32'd0);
    @(negedge clk);
    op = 4'd0; rd = 2'd2;
    #1;
    check("mtlo_out", out, 32'h9ABCDEF0);
    check("mtlo_busy", 32'(busy), 32'd0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    run_vec("ign", '{4'd1, 32'd6, 32'd7, MULT_N, 1'b0, 32'd0, 32'd42}, 1'b1, 1'b0);
    run_vec("b2b", '{4'd2, 32'd3, 32'd4, MULT_N, 1'b0, 32'd0, 32'd12}, 1'b0, 1'b1);

    @(negedge clk);
    op = 4'd6; rd1 = 32'h0000BEEF;
    @(negedge clk);
    op = 4'd3; rd1 = 32'd100; rd2 = 32'd7;
    #1;
    check("rmid_start", 32'(start), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      op = 4'd0;
    end
    #1;
    check("rmid_busy4", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_hi", hi, 32'd0);
    check("rmid_lo", lo, 32'd0);
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
      if (busy || hi !== 32'd0 || lo !== 32'd0) bad++;
    end
    check("rmid_late", 32'(bad), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
